// File: rtl/lcd_reader.sv
// lcd_reader: HD44780 read-side engine. Returns status (BF+AC) or one data byte, polling BF before data reads.
// Latency: status E(2+N), data E(5+2N) from the accept edge, plus POLL_GAP_CYC+N per busy poll (N = EN_HIGH_CYC).
// Backpressure: edge-triggered requests; edges while oBusy=1 are dropped. Optional timeout via LCD_RD_TIMEOUT_EN.
module lcd_reader #(
  parameter int EN_HIGH_CYC  = 4,
  parameter int POLL_GAP_CYC = 500   // must be >= 2
`ifdef LCD_RD_TIMEOUT_EN
  , parameter int TIMEOUT_POLLS = 32
`endif
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iRS,
  input  logic       iStart,
  output logic [7:0] oDATA,
  output logic       oDone,
  output logic       oBusy,
`ifdef LCD_RD_TIMEOUT_EN
  output logic       oErr,
`endif
  input  logic [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN
);

  localparam int MAXC = (EN_HIGH_CYC > POLL_GAP_CYC) ? EN_HIGH_CYC : POLL_GAP_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  // EN is registered from the state, so it lags by one edge: EN_BF/EN_RD dwell N+1 cycles
  // to give N cycles of EN high, and POLL_WAIT dwells one cycle less than the EN-low gap.
  localparam logic [CW-1:0] EN_LAST  = CW'(EN_HIGH_CYC);
  localparam logic [CW-1:0] GAP_LAST = CW'((POLL_GAP_CYC >= 2) ? POLL_GAP_CYC - 2 : 0);

`ifdef LCD_RD_TIMEOUT_EN
  localparam int PW = $clog2(TIMEOUT_POLLS + 1);
  localparam logic [PW-1:0] TO_LAST = PW'(TIMEOUT_POLLS - 1);
  logic [PW-1:0] r_polls, w_polls_nxt;
  logic          w_err_nxt;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP_BF, S_EN_BF, S_POLL_WAIT, S_HOLD, S_SETUP_RD, S_EN_RD
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_start_prev;
  logic          r_rs_lat, w_rs_lat_nxt;
  logic [7:0]    w_data_nxt;
  logic          w_done_nxt, w_busy_nxt, w_en_nxt, w_rs_nxt;
  logic          w_start_acc;

  assign LCD_RW      = 1'b1;
  assign w_start_acc = ~r_start_prev & iStart & (r_state == S_IDLE);

  // Next-state and next-output decode; outputs are registered from the current state.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt + 1'b1;
    w_rs_lat_nxt = r_rs_lat;
    w_data_nxt   = oDATA;
    w_done_nxt   = oDone;
    w_busy_nxt   = oBusy;
    w_en_nxt     = 1'b0;
    w_rs_nxt     = 1'b0;
`ifdef LCD_RD_TIMEOUT_EN
    w_polls_nxt  = r_polls;
    w_err_nxt    = oErr;
`endif
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_start_acc) begin
          w_state_nxt  = S_SETUP_BF;
          w_rs_lat_nxt = iRS;
          w_done_nxt   = 1'b0;
          w_busy_nxt   = 1'b1;
`ifdef LCD_RD_TIMEOUT_EN
          w_polls_nxt  = '0;
          w_err_nxt    = 1'b0;
`endif
        end
      end
      S_SETUP_BF: begin
        w_state_nxt = S_EN_BF;
        w_cnt_nxt   = '0;
      end
      S_EN_BF: begin
        w_en_nxt = 1'b1;
        if (r_cnt == EN_LAST) begin
          w_en_nxt  = 1'b0;
          w_cnt_nxt = '0;
          if (LCD_DATA[7]) begin
`ifdef LCD_RD_TIMEOUT_EN
            if (r_polls == TO_LAST) begin
              w_state_nxt = S_IDLE;
              w_data_nxt  = LCD_DATA;
              w_err_nxt   = 1'b1;
              w_done_nxt  = 1'b1;
              w_busy_nxt  = 1'b0;
            end else begin
              w_polls_nxt = r_polls + 1'b1;
              w_state_nxt = S_POLL_WAIT;
            end
`else
            w_state_nxt = S_POLL_WAIT;
`endif
          end else if (!r_rs_lat) begin
            w_state_nxt = S_IDLE;
            w_data_nxt  = LCD_DATA;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
          end else begin
            w_state_nxt = S_HOLD;
          end
        end
      end
      S_POLL_WAIT: begin
        if (r_cnt == GAP_LAST) begin
          w_state_nxt = S_EN_BF;
          w_cnt_nxt   = '0;
        end
      end
      S_HOLD: begin
        w_state_nxt = S_SETUP_RD;
        w_cnt_nxt   = '0;
      end
      S_SETUP_RD: begin
        w_rs_nxt    = 1'b1;
        w_state_nxt = S_EN_RD;
        w_cnt_nxt   = '0;
      end
      S_EN_RD: begin
        w_rs_nxt = 1'b1;
        w_en_nxt = 1'b1;
        if (r_cnt == EN_LAST) begin
          w_en_nxt    = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
          w_data_nxt  = LCD_DATA;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter and registered outputs; reset drops EN at once and reports nothing.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_start_prev <= 1'b0;
      r_rs_lat     <= 1'b0;
      oDATA        <= 8'h00;
      oDone        <= 1'b0;
      oBusy        <= 1'b0;
      LCD_EN       <= 1'b0;
      LCD_RS       <= 1'b0;
`ifdef LCD_RD_TIMEOUT_EN
      r_polls      <= '0;
      oErr         <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_start_prev <= iStart;
      r_rs_lat     <= w_rs_lat_nxt;
      oDATA        <= w_data_nxt;
      oDone        <= w_done_nxt;
      oBusy        <= w_busy_nxt;
      LCD_EN       <= w_en_nxt;
      LCD_RS       <= w_rs_nxt;
`ifdef LCD_RD_TIMEOUT_EN
      r_polls      <= w_polls_nxt;
      oErr         <= w_err_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_lcd_reader.sv
// tb_lcd_reader: drives lcd_reader against a panel bus model and a timing/result reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_lcd_reader;
  localparam int N  = 4;
  localparam int G  = 500;
  localparam int TO = 32;

  logic       iCLK = 1'b0;
  logic       iRST_N, iRS, iStart;
  logic [7:0] oDATA, LCD_DATA;
  logic       oDone, oBusy, LCD_RS, LCD_RW, LCD_EN;
`ifdef LCD_RD_TIMEOUT_EN
  logic       oErr;
`endif

  lcd_reader dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iRS(iRS), .iStart(iStart),
    .oDATA(oDATA), .oDone(oDone), .oBusy(oBusy),
`ifdef LCD_RD_TIMEOUT_EN
    .oErr(oErr),
`endif
    .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN)
  );

  always #5 iCLK = ~iCLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Panel model: bytes are presented on each EN rise according to the RS line.
  logic [7:0] bf_q[$];
  logic [7:0] data_byte;
  logic       stuck;
  int         en_pulses, rs1_pulses, rs_viol, busy_rises;

  always @(posedge LCD_EN) begin
    en_pulses++;
    if (LCD_RS) begin
      rs1_pulses++;
      LCD_DATA = data_byte;
    end else if (stuck) begin
      LCD_DATA = 8'hFF;
    end else if (bf_q.size() > 0) begin
      LCD_DATA = bf_q.pop_front();
    end else begin
      LCD_DATA = 8'h00;
    end
  end

  always @(LCD_RS) if (iRST_N === 1'b1 && LCD_EN === 1'b1) rs_viol++;
  always @(posedge oBusy) busy_rises++;

  // One request: rs type, number of busy polls, final status byte, data byte; glitch re-pulses iStart.
  task automatic run_txn(input logic rs, input int polls, input logic [7:0] ac_byte,
                         input logic [7:0] dbyte, input bit glitch);
    int exp_lat, n, lim;
    logic [7:0] exp_data;
    bf_q.delete();
    for (int i = 0; i < polls; i++) bf_q.push_back({1'b1, 7'($urandom)});
    bf_q.push_back({1'b0, ac_byte[6:0]});
    data_byte  = dbyte;
    stuck      = 1'b0;
    en_pulses  = 0;
    rs1_pulses = 0;
    rs_viol    = 0;
    busy_rises = 0;
    exp_lat  = (rs ? 5 + 2 * N : 2 + N) + polls * (G + N);
    exp_data = rs ? dbyte : {1'b0, ac_byte[6:0]};
    lim      = exp_lat + 50;

    @(negedge iCLK);
    iRS    = rs;
    iStart = 1'b1;
    @(posedge iCLK); #1;
    check("accept_busy", oBusy, 1);
    check("accept_done_clr", oDone, 0);
    n = 0;
    while (oDone !== 1'b1 && n < lim) begin
      @(posedge iCLK); #1;
      n++;
      if (glitch && n == 3) iStart = 1'b0;
      if (glitch && n == 5) iStart = 1'b1;
    end
    check("latency", n, exp_lat);
    check("data", oDATA, exp_data);
    check("busy_end", oBusy, 0);
    check("en_pulses", en_pulses, polls + 1 + (rs ? 1 : 0));
    check("rs1_pulses", rs1_pulses, rs ? 1 : 0);
    check("rs_stable", rs_viol, 0);
`ifdef LCD_RD_TIMEOUT_EN
    check("err_clear", oErr, 0);
`endif
    repeat (3) @(posedge iCLK);
    #1;
    check("no_restart", oBusy, 0);
    check("done_hold", oDone, 1);
    check("single_accept", busy_rises, 1);
    check("rs_idle", LCD_RS, 0);
    @(negedge iCLK);
    iStart = 1'b0;
  endtask

  initial begin
    int n;
    iRST_N   = 1'b0;
    iStart   = 1'b0;
    iRS      = 1'b0;
    LCD_DATA = 8'h00;
    stuck    = 1'b0;
    data_byte = 8'h00;
    repeat (3) @(posedge iCLK);
    #1;
    check("rst_data", oDATA, 8'h00);
    check("rst_done", oDone, 0);
    check("rst_busy", oBusy, 0);
    check("rst_en", LCD_EN, 0);
    check("rst_rs", LCD_RS, 0);
    check("rst_rw", LCD_RW, 1);
`ifdef LCD_RD_TIMEOUT_EN
    check("rst_err", oErr, 0);
`endif
    @(negedge iCLK);
    iRST_N = 1'b1;
    repeat (2) @(negedge iCLK);

    run_txn(1'b0, 0, 8'h25, 8'h00, 1'b0);
    run_txn(1'b1, 0, 8'h03, 8'h41, 1'b0);
    run_txn(1'b1, 2, 8'h00, 8'h5A, 1'b0);
    run_txn(1'b1, 0, 8'h11, 8'hC3, 1'b1);

    // Reset while the data pulse is high.
    bf_q.delete();
    bf_q.push_back(8'h07);
    data_byte = 8'h99;
    @(negedge iCLK);
    iRS    = 1'b1;
    iStart = 1'b1;
    n = 0;
    while (!(LCD_RS === 1'b1 && LCD_EN === 1'b1) && n < 100) begin
      @(posedge iCLK); #1;
      n++;
    end
    check("reach_en_rd", n < 100, 1);
    #2 iRST_N = 1'b0;
    #1;
    check("midrst_en", LCD_EN, 0);
    check("midrst_busy", oBusy, 0);
    check("midrst_done", oDone, 0);
    iStart = 1'b0;
    repeat (2) @(negedge iCLK);
    iRST_N = 1'b1;
    @(negedge iCLK);

    for (int t = 0; t < 6; t++)
      run_txn(1'($urandom), $urandom_range(0, 2), 8'($urandom), 8'($urandom), 1'b0);

`ifdef LCD_RD_TIMEOUT_EN
    // Stuck-busy panel: abort after TO polls, never touching data.
    stuck      = 1'b1;
    en_pulses  = 0;
    rs1_pulses = 0;
    @(negedge iCLK);
    iRS    = 1'b1;
    iStart = 1'b1;
    @(posedge iCLK); #1;
    n = 0;
    while (oDone !== 1'b1 && n < 20000) begin
      @(posedge iCLK); #1;
      n++;
    end
    check("to_latency", n, 2 + N + (TO - 1) * (G + N));
    check("to_pulses", en_pulses, TO);
    check("to_rs1", rs1_pulses, 0);
    check("to_err", oErr, 1);
    check("to_data", oDATA, 8'hFF);
    check("to_busy", oBusy, 0);
    @(negedge iCLK);
    iStart = 1'b0;
    stuck  = 1'b0;
    run_txn(1'b0, 1, 8'h2C, 8'h00, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/lcd_reader.md
# lcd_reader

Read-side companion to the LCD1602 write driver: on request, reads either the busy-flag/address-counter byte or one DDRAM/CGRAM data byte from the HD44780-compatible panel and returns it to the host. Before every data read it polls the busy flag until the panel is idle. Sits between host control logic and the LCD bus. The bus is shared with the write driver, and `oBusy` is used for arbitration.

## Interface
- `EN_HIGH_CYC`, default 4: iCLK cycles LCD_EN is held high per access; sampling happens on the last one.
- `POLL_GAP_CYC`, default 500: iCLK cycles LCD_EN is held low between busy polls (0.5 ms at 1 MHz).
- `TIMEOUT_POLLS`, default 32: consecutive busy samples before abort. Used only with the timeout feature.
- `iCLK` input 1: 1 MHz clock. The block uses this one clock only.
- `iRST_N` input 1: asynchronous, active-low reset.
- `iRS` input 1: request type, 0 = status read (BF+AC), 1 = data read. Latched at start.
- `iStart` input 1: a rising edge requests a transaction.
- `oDATA` output 8: returned byte. Holds its value until the next completion.
- `oDone` output 1: rises on completion. Stays high until the next accepted start.
- `oBusy` output 1: high from the start-detect edge through the completion edge.
- `oErr` output 1: timeout abort flag. Present only with `LCD_RD_TIMEOUT_EN`.
- `LCD_DATA` input 8: panel data bus. This block never drives it.
- `LCD_RS` output 1, `LCD_RW` output 1, `LCD_EN` output 1: panel control lines.

## Operation
- Start detect: the previous-cycle copy of iStart is registered. A start is accepted when the sampled pair {prev, iStart} = 01 and the FSM is in IDLE. Edges while oBusy=1 are ignored. Accepting a start latches iRS, clears oDone/oErr and sets oBusy.
- FSM states:
  - IDLE: waits for an accepted start, then goes to SETUP_BF.
  - SETUP_BF: LCD_RS=0, LCD_RW=1, LCD_EN=0. Lasts 1 cycle, then EN_BF.
  - EN_BF: LCD_EN=1 for EN_HIGH_CYC cycles. On the last edge it samples LCD_DATA and drops LCD_EN.
    - If bit7=1, go to POLL_WAIT.
    - Else if the latched RS=0: oDATA = sample, oDone=1, go to IDLE.
    - Else go to HOLD.
  - POLL_WAIT: LCD_EN=0 for POLL_GAP_CYC cycles, then EN_BF. RS/RW are unchanged.
  - HOLD: LCD_EN=0 for 1 cycle (address hold), then SETUP_RD.
  - SETUP_RD: LCD_RS=1 for 1 cycle, then EN_RD.
  - EN_RD: LCD_EN=1 for EN_HIGH_CYC cycles. On the last edge it samples into oDATA, drops LCD_EN, sets oDone=1 and goes to IDLE.
- In IDLE, LCD_RS returns to 0 on the first edge. LCD_RW is constant 1.
- A single cycle counter, wide enough for max(EN_HIGH_CYC, POLL_GAP_CYC), is reset on every state entry.
- The status byte is returned raw: bit7 = BF, bits[6:0] = AC. A data read advances the panel's AC; that is panel behaviour, not this block's.

## Timing
- Reset values (applied asynchronously): oDATA=8'h00, oDone=0, oBusy=0, oErr=0, LCD_RS=0, LCD_RW=1, LCD_EN=0, FSM=IDLE, counter=0.
- Reset mid-transaction: LCD_EN falls immediately and no completion is reported.
- Edges are counted from the start-accept edge E0.
- Status read, not busy: LCD_EN rises at E2 and falls at E(2+N), with N = EN_HIGH_CYC. oDone=1 and oBusy=0 at E(2+N), i.e. E6 by default.
- Data read, not busy: first pulse as above; LCD_RS rises at E(4+N); second LCD_EN pulse from E(5+N) to E(5+2N). oDone at E(5+2N), i.e. E13 by default.
- Each busy poll adds POLL_GAP_CYC + N cycles.
- LCD_RS never changes while LCD_EN=1.

## Configuration
- `LCD_RD_TIMEOUT_EN` defined: oErr exists. After TIMEOUT_POLLS consecutive samples with bit7=1, the transaction aborts:
  - LCD_EN=0, oDATA = last status byte, oErr=1, oDone=1, go to IDLE.
  - No data access is performed.
- `LCD_RD_TIMEOUT_EN` undefined: oErr is absent and polling continues indefinitely.

## Test plan
- Status read, bus model returns 8'h25: oDATA=8'h25 and oDone at E6; one 4-cycle LCD_EN pulse with RS=0, RW=1.
- Data read, BF byte 8'h03 then data 8'h41: oDATA=8'h41 at E13; two LCD_EN pulses; RS=1 only around the second; RS stable whenever EN=1.
- Data read with BF=8'h80 for two polls, then 8'h00, then data 8'h5A: three BF pulses with 500-cycle low gaps, then the data pulse; oDATA=8'h5A.
- iStart re-pulsed and held high mid-transaction: no restart, single completion. A new rising edge after oDone clears oDone on the accept edge.
- iRST_N asserted during EN_RD: LCD_EN=0, oBusy=0, oDone=0 immediately. The next request after reset completes normally.
- `LCD_RD_TIMEOUT_EN` on, BF stuck at 8'hFF, TIMEOUT_POLLS=32: 32 EN pulses, then oErr=1, oDone=1, oDATA=8'hFF, and no RS=1 access.
